// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-approach traffic controller.
// Holds the phase encoding, the interval table indices, the lamp bit
// positions inside each {R,Y,G} triple, and the mapping from each phase to
// the table entry that sets its duration.
package traffic_pkg;

  typedef enum logic [2:0] {
    CLEAR_INIT = 3'd0,
    GREEN      = 3'd1,
    EXTEND     = 3'd2,
    YELLOW     = 3'd3,
    ALLRED     = 3'd4,
    WALK       = 3'd5
  } state_t;

  localparam int unsigned IDX_BASE   = 0;
  localparam int unsigned IDX_EXTRA  = 1;
  localparam int unsigned IDX_YELLOW = 2;
  localparam int unsigned IDX_CLEAR  = 3;

  localparam int unsigned LIGHT_R = 2;
  localparam int unsigned LIGHT_Y = 1;
  localparam int unsigned LIGHT_G = 0;

  // Interval table entry that sets how long a phase lasts
  function automatic logic [1:0] entry_of(input state_t s);
    logic [1:0] idx;
    idx = 2'(IDX_CLEAR);
    case (s)
      GREEN:         idx = 2'(IDX_BASE);
      EXTEND, WALK:  idx = 2'(IDX_EXTRA);
      YELLOW:        idx = 2'(IDX_YELLOW);
      default:       idx = 2'(IDX_CLEAR);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/traffic_ctrl_multi_phase_timer.sv
// Loadable countdown that measures the length of the current phase.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (loads RST_VAL)
//   tick      - one-cycle time-unit enable
//   load      - reload the count (wins over a tick in the same cycle)
//   load_val  - new count; a value of 0 is treated as 1
//   expire    - tick arrives while the count is at its last unit
module phase_timer #(
  parameter int unsigned       TIME_W  = 4,
  parameter logic [TIME_W-1:0] RST_VAL = TIME_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic              expire
);

  logic [TIME_W-1:0] cnt;

  assign expire = tick && (cnt <= TIME_W'(1));

  // Count holds at 1 so a zero-length interval still spans one tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= (RST_VAL == '0) ? TIME_W'(1) : RST_VAL;
    end else if (load) begin
      cnt <= (load_val == '0) ? TIME_W'(1) : load_val;
    end else if (tick && (cnt > TIME_W'(1))) begin
      cnt <= cnt - TIME_W'(1);
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic light controller for NUM_DIRS approaches with an
// integrated phase timer, programmable 4-entry interval table, latched
// pedestrian walk phase, optional idle-approach skipping and a single
// sensor-driven green extension per approach.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tick       - one-cycle time-unit enable
//   sensor     - vehicle present per approach (level)
//   walk_req   - pedestrian button (level or pulse)
//   prog_we    - interval table write; also restarts the cycle from all-red
//   prog_addr  - table entry select
//   prog_data  - interval value
//   lights     - {R,Y,G} per approach, approach d at [3d+2:3d]
//   walk       - walk lamp
//   walk_done  - one-cycle pulse as the walk phase ends
//   phase      - approach currently or most recently served
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS   = 2,
  parameter int unsigned TIME_W     = 4,
  parameter int unsigned WALK_AFTER = 0,
  parameter int unsigned SKIP_IDLE  = 0,
  parameter int unsigned DEF_BASE   = 6,
  parameter int unsigned DEF_EXTRA  = 3,
  parameter int unsigned DEF_YELLOW = 2,
  parameter int unsigned DEF_CLEAR  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [NUM_DIRS-1:0]         sensor,
  input  logic                        walk_req,
  input  logic                        prog_we,
  input  logic [1:0]                  prog_addr,
  input  logic [TIME_W-1:0]           prog_data,
  output logic [3*NUM_DIRS-1:0]       lights,
  output logic                        walk,
  output logic                        walk_done,
  output logic [$clog2(NUM_DIRS)-1:0] phase
);

  localparam int unsigned DIR_W = $clog2(NUM_DIRS);

  state_t            state_q, state_d;
  logic [DIR_W-1:0]  dir_q, dir_d, dir_next;
  logic [TIME_W-1:0] tbl [4];
  logic              walk_lat;
  logic              expire;
  logic              walk_exit;
  logic [1:0]        load_idx;
  logic [TIME_W-1:0] load_val;
  logic [3*NUM_DIRS-1:0] lights_d;

  function automatic logic [DIR_W-1:0] inc_dir(input logic [DIR_W-1:0] x);
    return (x == DIR_W'(NUM_DIRS - 1)) ? '0 : DIR_W'(x + DIR_W'(1));
  endfunction

  // Next approach; approach 0 is never skipped so NUM_DIRS steps always suffice
  always_comb begin
    dir_next = inc_dir(dir_q);
    for (int i = 0; i < int'(NUM_DIRS); i++) begin
      if ((SKIP_IDLE != 0) && (dir_next != '0) && !sensor[dir_next]) begin
        dir_next = inc_dir(dir_next);
      end
    end
  end

  // Next-state logic; a table write overrides any expiry in the same cycle
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (prog_we) begin
      state_d = CLEAR_INIT;
      dir_d   = '0;
    end else if (expire) begin
      case (state_q)
        CLEAR_INIT: begin
          state_d = GREEN;
          dir_d   = '0;
        end
        GREEN:  state_d = sensor[dir_q] ? EXTEND : YELLOW;
        EXTEND: state_d = YELLOW;
        YELLOW: state_d = ALLRED;
        ALLRED: begin
          if (walk_lat && (dir_q == DIR_W'(WALK_AFTER))) begin
            state_d = WALK;
          end else begin
            state_d = GREEN;
            dir_d   = dir_next;
          end
        end
        WALK: begin
          state_d = GREEN;
          dir_d   = dir_next;
        end
        default: begin
          state_d = CLEAR_INIT;
          dir_d   = '0;
        end
      endcase
    end
  end

  assign walk_exit = expire && !prog_we && (state_q == WALK);

  // Duration of the phase being entered; forward a same-cycle table write
  assign load_idx = entry_of(state_d);
  assign load_val = (prog_we && (prog_addr == load_idx)) ? prog_data : tbl[load_idx];

  phase_timer #(
    .TIME_W  (TIME_W),
    .RST_VAL (TIME_W'(DEF_CLEAR))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (prog_we || expire),
    .load_val (load_val),
    .expire   (expire)
  );

  // Lamp pattern for the phase being entered
  always_comb begin
    lights_d = '0;
    for (int d = 0; d < int'(NUM_DIRS); d++) begin
      lights_d[3*d + LIGHT_R] = 1'b1;
      if (DIR_W'(d) == dir_d) begin
        if ((state_d == GREEN) || (state_d == EXTEND)) begin
          lights_d[3*d + LIGHT_R] = 1'b0;
          lights_d[3*d + LIGHT_G] = 1'b1;
        end else if (state_d == YELLOW) begin
          lights_d[3*d + LIGHT_R] = 1'b0;
          lights_d[3*d + LIGHT_Y] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_INIT;
      dir_q     <= '0;
      tbl[IDX_BASE]   <= TIME_W'(DEF_BASE);
      tbl[IDX_EXTRA]  <= TIME_W'(DEF_EXTRA);
      tbl[IDX_YELLOW] <= TIME_W'(DEF_YELLOW);
      tbl[IDX_CLEAR]  <= TIME_W'(DEF_CLEAR);
      walk_lat  <= 1'b0;
      lights    <= {NUM_DIRS{3'b100}};
      walk      <= 1'b0;
      walk_done <= 1'b0;
      phase     <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      if (prog_we) begin
        tbl[prog_addr] <= prog_data;
      end
      // A request in the exit cycle survives the clear
      walk_lat  <= walk_req || (walk_lat && !walk_exit);
      lights    <= lights_d;
      walk      <= (state_d == WALK);
      walk_done <= walk_exit;
      phase     <= dir_d;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-approach instance with walk
// after approach 0, and a 4-approach instance with idle skipping.
module tb_traffic_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst, rst4, tick;
  logic [1:0]  sensor;
  logic [3:0]  sensor4;
  logic        walk_req, prog_we;
  logic [1:0]  prog_addr;
  logic [3:0]  prog_data;
  logic [5:0]  lights;
  logic        walk, walk_done;
  logic [0:0]  phase;
  logic [11:0] lights4;
  logic        walk4, walk_done4;
  logic [1:0]  phase4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] AR2 = 32'b100_100;
  localparam logic [31:0] G0  = 32'b100_001;
  localparam logic [31:0] Y0  = 32'b100_010;
  localparam logic [31:0] G1  = 32'b001_100;
  localparam logic [31:0] Y1  = 32'b010_100;
  localparam logic [31:0] AR4  = 32'b100_100_100_100;
  localparam logic [31:0] G0_4 = 32'b100_100_100_001;
  localparam logic [31:0] Y0_4 = 32'b100_100_100_010;
  localparam logic [31:0] G2_4 = 32'b100_001_100_100;
  localparam logic [31:0] Y2_4 = 32'b100_010_100_100;

  always #5 clk = ~clk;

  traffic_ctrl_multi #(
    .NUM_DIRS(2), .TIME_W(4), .WALK_AFTER(0), .SKIP_IDLE(0),
    .DEF_BASE(6), .DEF_EXTRA(3), .DEF_YELLOW(2), .DEF_CLEAR(1)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .sensor(sensor), .walk_req(walk_req),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .lights(lights), .walk(walk), .walk_done(walk_done), .phase(phase)
  );

  traffic_ctrl_multi #(
    .NUM_DIRS(4), .TIME_W(4), .WALK_AFTER(0), .SKIP_IDLE(1),
    .DEF_BASE(6), .DEF_EXTRA(3), .DEF_YELLOW(2), .DEF_CLEAR(1)
  ) dut4 (
    .clk(clk), .rst(rst4), .tick(tick), .sensor(sensor4), .walk_req(1'b0),
    .prog_we(1'b0), .prog_addr(2'b00), .prog_data(4'b0000),
    .lights(lights4), .walk(walk4), .walk_done(walk_done4), .phase(phase4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive tick windows against one expected output set
  task automatic seg(input bit four, input string tag, input logic [31:0] exp_l,
                     input bit exp_w, input logic [31:0] exp_p, input bit wd_first,
                     input int n);
    for (int i = 0; i < n; i++) begin
      if (four) begin
        check($sformatf("%s[%0d].lights", tag, i), 32'(lights4), exp_l);
        check($sformatf("%s[%0d].phase", tag, i), 32'(phase4), exp_p);
        check($sformatf("%s[%0d].walk", tag, i), 32'(walk4), 32'(exp_w));
        check($sformatf("%s[%0d].walk_done", tag, i), 32'(walk_done4), 32'd0);
      end else begin
        check($sformatf("%s[%0d].lights", tag, i), 32'(lights), exp_l);
        check($sformatf("%s[%0d].phase", tag, i), 32'(phase), exp_p);
        check($sformatf("%s[%0d].walk", tag, i), 32'(walk), 32'(exp_w));
        check($sformatf("%s[%0d].walk_done", tag, i), 32'(walk_done),
              32'((i == 0) ? wd_first : 1'b0));
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1; tick = 1'b1;
    sensor = 2'b00; sensor4 = 4'b0100;
    walk_req = 1'b0; prog_we = 1'b0; prog_addr = 2'd0; prog_data = 4'd0;
    step(); step();
    seg(0, "reset", AR2, 0, 0, 0, 1);
    rst = 1'b0;

    // Default cycle, no sensors
    seg(0, "init",  AR2, 0, 0, 0, 1);
    seg(0, "g0",    G0,  0, 0, 0, 6);
    seg(0, "y0",    Y0,  0, 0, 0, 2);
    seg(0, "ar0",   AR2, 0, 0, 0, 1);
    seg(0, "g1",    G1,  0, 1, 0, 6);
    seg(0, "y1",    Y1,  0, 1, 0, 2);
    seg(0, "ar1",   AR2, 0, 1, 0, 1);

    // Single extension on approach 0
    sensor = 2'b01;
    seg(0, "g0ext", G0,  0, 0, 0, 9);
    seg(0, "y0ext", Y0,  0, 0, 0, 2);
    seg(0, "ar0ext", AR2, 0, 0, 0, 1);
    seg(0, "g1ext", G1,  0, 1, 0, 6);
    seg(0, "y1ext", Y1,  0, 1, 0, 2);
    seg(0, "ar1ext", AR2, 0, 1, 0, 1);
    sensor = 2'b00;

    // Walk request pulse during G1; walk inserted only after approach 0
    seg(0, "w_g0",  G0,  0, 0, 0, 6);
    seg(0, "w_y0",  Y0,  0, 0, 0, 2);
    seg(0, "w_ar0", AR2, 0, 0, 0, 1);
    walk_req = 1'b1;
    seg(0, "w_g1a", G1,  0, 1, 0, 1);
    walk_req = 1'b0;
    seg(0, "w_g1b", G1,  0, 1, 0, 5);
    seg(0, "w_y1",  Y1,  0, 1, 0, 2);
    seg(0, "w_ar1", AR2, 0, 1, 0, 1);
    seg(0, "w_g0b", G0,  0, 0, 0, 6);
    seg(0, "w_y0b", Y0,  0, 0, 0, 2);
    seg(0, "w_ar0b", AR2, 0, 0, 0, 1);
    seg(0, "walk1", AR2, 1, 0, 0, 3);
    seg(0, "w_g1c", G1,  0, 1, 1, 6);
    seg(0, "w_y1c", Y1,  0, 1, 0, 2);
    seg(0, "w_ar1c", AR2, 0, 1, 0, 1);

    // Request held through the walk exit keeps the latch set
    walk_req = 1'b1;
    seg(0, "h_g0",  G0,  0, 0, 0, 6);
    seg(0, "h_y0",  Y0,  0, 0, 0, 2);
    seg(0, "h_ar0", AR2, 0, 0, 0, 1);
    seg(0, "h_walk", AR2, 1, 0, 0, 3);
    walk_req = 1'b0;
    seg(0, "h_g1",  G1,  0, 1, 1, 6);
    seg(0, "h_y1",  Y1,  0, 1, 0, 2);
    seg(0, "h_ar1", AR2, 0, 1, 0, 1);
    seg(0, "h_g0b", G0,  0, 0, 0, 6);
    seg(0, "h_y0b", Y0,  0, 0, 0, 2);
    seg(0, "h_ar0b", AR2, 0, 0, 0, 1);
    seg(0, "h_walk2", AR2, 1, 0, 0, 3);
    seg(0, "h_g1b", G1,  0, 1, 1, 6);
    seg(0, "h_y1b", Y1,  0, 1, 0, 2);
    seg(0, "h_ar1b", AR2, 0, 1, 0, 1);

    // Program yellow = 0 mid-G0: immediate restart, yellows become 1 tick
    seg(0, "p_g0",  G0,  0, 0, 0, 2);
    prog_we = 1'b1; prog_addr = 2'd2; prog_data = 4'd0;
    seg(0, "p_wr",  G0,  0, 0, 0, 1);
    prog_we = 1'b0;
    seg(0, "p_clr", AR2, 0, 0, 0, 1);
    seg(0, "p_g0b", G0,  0, 0, 0, 6);
    seg(0, "p_y0",  Y0,  0, 0, 0, 1);
    seg(0, "p_ar0", AR2, 0, 0, 0, 1);
    seg(0, "p_g1",  G1,  0, 1, 0, 6);
    seg(0, "p_y1",  Y1,  0, 1, 0, 1);
    seg(0, "p_ar1", AR2, 0, 1, 0, 1);

    // Reset beats a simultaneous write and restores the default yellow
    rst = 1'b1; prog_we = 1'b1; prog_addr = 2'd2; prog_data = 4'd5;
    seg(0, "r_g0",  G0,  0, 0, 0, 1);
    rst = 1'b0; prog_we = 1'b0;
    seg(0, "r_init", AR2, 0, 0, 0, 1);
    seg(0, "r_g0b", G0,  0, 0, 0, 6);
    seg(0, "r_y0",  Y0,  0, 0, 0, 2);
    seg(0, "r_ar0", AR2, 0, 0, 0, 1);

    // Missing ticks stretch the phase
    tick = 1'b0;
    seg(0, "t_hold", G1, 0, 1, 0, 3);
    tick = 1'b1;
    seg(0, "t_g1",  G1,  0, 1, 0, 6);
    seg(0, "t_y1",  Y1,  0, 1, 0, 2);

    // Four approaches, idle skipping, only approach 2 occupied
    rst4 = 1'b0;
    seg(1, "s_init", AR4,  0, 0, 0, 1);
    seg(1, "s_g0",   G0_4, 0, 0, 0, 6);
    seg(1, "s_y0",   Y0_4, 0, 0, 0, 2);
    seg(1, "s_ar0",  AR4,  0, 0, 0, 1);
    seg(1, "s_g2",   G2_4, 0, 2, 0, 9);
    seg(1, "s_y2",   Y2_4, 0, 2, 0, 2);
    seg(1, "s_ar2",  AR4,  0, 2, 0, 1);
    seg(1, "s_g0b",  G0_4, 0, 0, 0, 6);
    seg(1, "s_y0b",  Y0_4, 0, 0, 0, 2);
    seg(1, "s_ar0b", AR4,  0, 0, 0, 1);
    seg(1, "s_g2b",  G2_4, 0, 2, 0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
- Parametrised successor to the two-road traffic FSM. Sequences green/yellow/all-red phases round-robin across NUM_DIRS approaches.
- Integrates the interval countdown timer (no external start/expired handshake), driven by a 1-unit `tick` enable.
- Holds a programmable 4-entry interval table.
- Adds a latched pedestrian request, optional skipping of idle approaches, and a per-approach single sensor extension.

Parameters:
- NUM_DIRS, 2, number of approaches (2..8); approach 0 is the main road.
- TIME_W, 4, width of interval values and countdown.
- WALK_AFTER, 0, approach index after whose clearance a pending walk phase is inserted.
- SKIP_IDLE, 0, 1 = skip approach d≠0 whose sensor is low when it would be entered.
- DEF_BASE, 6, reset value of table entry 0 (base green).
- DEF_EXTRA, 3, reset value of entry 1 (green extension and walk length).
- DEF_YELLOW, 2, reset value of entry 2 (yellow).
- DEF_CLEAR, 1, reset value of entry 3 (all-red clearance).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle time-unit enable
- sensor  in  NUM_DIRS  vehicle-present per approach, level
- walk_req  in  1  pedestrian button, level or pulse
- prog_we  in  1  interval table write strobe
- prog_addr  in  2  table entry select
- prog_data  in  TIME_W  interval value
- lights  out  3*NUM_DIRS  per approach {R,Y,G}, approach d at bits [3d+2:3d]
- walk  out  1  walk lamp
- walk_done  out  1  one-cycle pulse when the walk phase ends
- phase  out  clog2(NUM_DIRS)  approach currently or most recently served

Behaviour:
- Reset values:
  - state CLEAR_INIT, dir = 0, table = DEF_*, countdown = DEF_CLEAR.
  - All R = 1, all Y/G = 0; walk = 0, walk_done = 0, phase = 0, walk latch = 0.
- Timer:
  - On state entry, load cnt = table[entry]; an entry value of 0 is treated as 1.
  - On each tick with cnt > 1, decrement cnt.
  - expire = tick && cnt ≤ 1.
  - State advances in the expire cycle.
- States and transitions (only on expire):
  - CLEAR_INIT (CLEAR) → GREEN(0).
  - GREEN(d) (BASE) → EXTEND(d) if sensor[d], else YELLOW(d).
  - EXTEND(d) (EXTRA) → YELLOW(d). There is never a second extension.
  - YELLOW(d) (YELLOW) → ALLRED(d).
  - ALLRED(d) (CLEAR) → WALK if walk latch is set and d == WALK_AFTER; otherwise GREEN(next).
  - WALK (EXTRA) → GREEN(next). Clears the latch; walk_done pulses 1 cycle.
- next = (d+1) mod NUM_DIRS.
  - If SKIP_IDLE, repeatedly advance past approaches d≠0 with sensor low, sampled in the transition cycle.
  - Approach 0 is never skipped, so the search terminates within NUM_DIRS steps.
- Outputs are registered from state, 1-cycle latency:
  - GREEN/EXTEND(d): G[d] = 1, every other approach R.
  - YELLOW(d): Y[d] = 1, every other approach R.
  - ALLRED, CLEAR_INIT, WALK: all R; walk = 1 only in WALK.
  - phase = d.
- Walk latch:
  - Set by walk_req in any cycle; cleared on the WALK exit.
  - If walk_req is high in the WALK-exit cycle, the latch stays set and a new request is recorded.
- Programming:
  - prog_we writes table[prog_addr] <= prog_data.
  - It also forces CLEAR_INIT with dir = 0, reloads the timer, and clears walk_done.
  - The walk latch is preserved.
- Priority: rst > prog_we > expire. A tick coinciding with prog_we is ignored.
- Reset mid-phase: the next cycle is all red with the table restored to defaults.
- Sensors are sampled only at expire edges and are not latched.

Decomposition:
- Package traffic_pkg holds:
  - state encoding constants: CLEAR_INIT, GREEN, EXTEND, YELLOW, ALLRED, WALK;
  - table indices: IDX_BASE = 0, IDX_EXTRA = 1, IDX_YELLOW = 2, IDX_CLEAR = 3;
  - light bit positions R = 2, Y = 1, G = 0.
- One sub-module: phase_timer, which contains the loadable countdown and expire generation. It takes load, load_val, tick and rst, and returns expire.

Test Plan:
- Reset, NUM_DIRS = 2, defaults, tick every cycle, no sensors:
  - lights = 3'b100 per approach for 1 tick, then G0 for 6 ticks, Y0 for 2 ticks, all-red for 1 tick, then G1.
  - phase goes 0 → 1 → 0.
- sensor[0] held high:
  - G0 lasts 6 + 3 = 9 ticks.
  - Exactly one extension occurs, then Y0.
- walk_req pulse during G1, WALK_AFTER = 0:
  - No walk after approach 1.
  - After ALLRED(0): walk = 1 and all red for 3 ticks, walk_done pulses once, then G1.
- NUM_DIRS = 4, SKIP_IDLE = 1, only sensor[2] high:
  - Sequence is 0 → 2 → 0.
  - Approaches 1 and 3 are never green.
- prog_we addr 2, data 0 during G0:
  - Immediate all red (CLEAR_INIT).
  - The following yellows last 1 tick.
  - rst asserted with prog_we in the same cycle restores yellow = 2.
- walk_req held through the WALK exit cycle:
  - The latch remains set.
  - A second walk phase occurs on the next WALK_AFTER clearance.
